// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer.
// Captures instruction, PC and PC+1 from fetch and presents them to decode.
// Flush squashes everything held plus the same-cycle fetch. A saturating
// counter records the cycles in which decode stalls a valid instruction.
//
// Handshake: a transfer happens on a rising edge when valid and ready are
// both high on that interface (if_valid/if_ready upstream, id_valid/id_ready
// downstream). valid never depends on ready. if_ready is decoded from
// registered state only, so there is no combinational path id_ready -> if_ready.
module if_id_skid_reg #(
    parameter int          AddrSize  = 32,
    parameter int          Inst_Size = 32,
    parameter logic [31:0] NOP_Inst  = 32'h00000013,
    parameter int          CntWidth  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_valid,
    input  logic [Inst_Size-1:0] if_inst,
    input  logic [AddrSize-1:0]  if_pc,
    input  logic [AddrSize-1:0]  if_pc_plus,
    output logic                 if_ready,
    input  logic                 flush,
    input  logic                 id_ready,
    output logic                 id_valid,
    output logic [Inst_Size-1:0] id_inst,
    output logic [AddrSize-1:0]  id_pc,
    output logic [AddrSize-1:0]  id_pc_plus,
    output logic [CntWidth-1:0]  stall_cnt,
    output logic [1:0]           dbg_state
);

    localparam logic [1:0] EMPTY = 2'd0;  // nothing held
    localparam logic [1:0] FULL  = 2'd1;  // OUT valid
    localparam logic [1:0] SKID  = 2'd2;  // OUT and SKD valid

    localparam logic [Inst_Size-1:0] NopWord = Inst_Size'(NOP_Inst);
    localparam logic [CntWidth-1:0]  CntMax  = {CntWidth{1'b1}};

    logic [1:0]           state;
    logic [Inst_Size-1:0] out_inst;
    logic [AddrSize-1:0]  out_pc;
    logic [AddrSize-1:0]  out_pc_plus;
    logic [Inst_Size-1:0] skd_inst;
    logic [AddrSize-1:0]  skd_pc;
    logic [AddrSize-1:0]  skd_pc_plus;
    logic                 accept;
    logic                 deliver;

    assign if_ready   = (state != SKID);
    assign id_valid   = (state != EMPTY);
    assign id_inst    = out_inst;
    assign id_pc      = out_pc;
    assign id_pc_plus = out_pc_plus;
    assign dbg_state  = state;

    assign accept  = if_valid & if_ready;
    assign deliver = id_valid & id_ready;

    // Occupancy state machine; flush overrides every transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) state <= FULL;
                FULL: begin
                    if (accept && !deliver)      state <= SKID;
                    else if (!accept && deliver) state <= EMPTY;
                end
                SKID: if (deliver) state <= FULL;
                default: state <= EMPTY;
            endcase
        end
    end

    // Output register: loads from fetch or from SKD; bubbles to NOP when emptied.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_inst    <= NopWord;
            out_pc      <= '0;
            out_pc_plus <= '0;
        end else if (flush) begin
            out_inst <= NopWord;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_inst    <= if_inst;
                        out_pc      <= if_pc;
                        out_pc_plus <= if_pc_plus;
                    end
                end
                FULL: begin
                    if (accept && deliver) begin
                        out_inst    <= if_inst;
                        out_pc      <= if_pc;
                        out_pc_plus <= if_pc_plus;
                    end else if (!accept && deliver) begin
                        out_inst <= NopWord;
                    end
                end
                SKID: begin
                    if (deliver) begin
                        out_inst    <= skd_inst;
                        out_pc      <= skd_pc;
                        out_pc_plus <= skd_pc_plus;
                    end
                end
                default: out_inst <= NopWord;
            endcase
        end
    end

    // Skid register: catches the fetch accepted while decode is stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skd_inst    <= '0;
            skd_pc      <= '0;
            skd_pc_plus <= '0;
        end else if (!flush && state == FULL && accept && !deliver) begin
            skd_inst    <= if_inst;
            skd_pc      <= if_pc;
            skd_pc_plus <= if_pc_plus;
        end
    end

    // Saturating count of decode stall cycles; a flush cycle is not a stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (id_valid && !id_ready && !flush && stall_cnt != CntMax) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed bench for if_id_skid_reg (stall counter narrowed to 4 bits).
module tb_if_id_skid_reg;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_FULL  = 2'd1;
    localparam logic [1:0] S_SKID  = 2'd2;

    logic        clk;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus;
    logic        if_ready;
    logic        flush;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus;
    logic [3:0]  stall_cnt;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    if_id_skid_reg #(
        .AddrSize (32),
        .Inst_Size(32),
        .NOP_Inst (32'h00000013),
        .CntWidth (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_valid  (if_valid),
        .if_inst   (if_inst),
        .if_pc     (if_pc),
        .if_pc_plus(if_pc_plus),
        .if_ready  (if_ready),
        .flush     (flush),
        .id_ready  (id_ready),
        .id_valid  (id_valid),
        .id_inst   (id_inst),
        .id_pc     (id_pc),
        .id_pc_plus(id_pc_plus),
        .stall_cnt (stall_cnt),
        .dbg_state (dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        if_valid   = v;
        if_inst    = inst;
        if_pc      = pc;
        if_pc_plus = pc + 32'd1;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        id_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #2 reset = 1'b0;
        #1;
        check("por_id_valid", 32'(id_valid), 32'd0);
        check("por_if_ready", 32'(if_ready), 32'd1);
        check("por_id_inst", id_inst, 32'h13);
        check("por_id_pc", id_pc, 32'd0);
        check("por_stall", 32'(stall_cnt), 32'd0);
        tick();
        tick();
        #2 reset = 1'b1;
        tick();

        // Streaming A,B,C with decode always ready
        id_ready = 1'b1;
        drive(1'b1, 32'hA, 32'd0);
        tick();
        check("str_a_inst", id_inst, 32'hA);
        check("str_a_valid", 32'(id_valid), 32'd1);
        check("str_a_ifrdy", 32'(if_ready), 32'd1);
        drive(1'b1, 32'hB, 32'd1);
        tick();
        check("str_b_inst", id_inst, 32'hB);
        check("str_b_pc", id_pc, 32'd1);
        check("str_b_pcp", id_pc_plus, 32'd2);
        drive(1'b1, 32'hC, 32'd2);
        tick();
        check("str_c_inst", id_inst, 32'hC);
        check("str_c_ifrdy", 32'(if_ready), 32'd1);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("str_end_valid", 32'(id_valid), 32'd0);
        check("str_end_inst", id_inst, 32'h13);
        check("str_end_pc", id_pc, 32'd2);
        check("str_stall", 32'(stall_cnt), 32'd0);

        // Back-pressure: two stall cycles after A appears
        drive(1'b1, 32'hA, 32'd0);
        tick();
        check("bp_a_inst", id_inst, 32'hA);
        id_ready = 1'b0;
        drive(1'b1, 32'hB, 32'd1);
        tick();
        check("bp_s1_inst", id_inst, 32'hA);
        check("bp_s1_ifrdy", 32'(if_ready), 32'd0);
        check("bp_s1_state", 32'(dbg_state), 32'(S_SKID));
        check("bp_s1_stall", 32'(stall_cnt), 32'd1);
        drive(1'b1, 32'hC, 32'd2);
        tick();
        check("bp_s2_inst", id_inst, 32'hA);
        check("bp_s2_ifrdy", 32'(if_ready), 32'd0);
        check("bp_s2_stall", 32'(stall_cnt), 32'd2);
        id_ready = 1'b1;
        tick();
        check("bp_b_inst", id_inst, 32'hB);
        check("bp_b_pc", id_pc, 32'd1);
        check("bp_b_ifrdy", 32'(if_ready), 32'd1);
        tick();
        check("bp_c_inst", id_inst, 32'hC);
        check("bp_c_pc", id_pc, 32'd2);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("bp_end_valid", 32'(id_valid), 32'd0);
        check("bp_end_stall", 32'(stall_cnt), 32'd2);

        // Flush while in SKID with a valid fetch D on the inputs
        id_ready = 1'b0;
        drive(1'b1, 32'hA, 32'd4);
        tick();
        check("fl_a_state", 32'(dbg_state), 32'(S_FULL));
        check("fl_a_stall", 32'(stall_cnt), 32'd2);
        drive(1'b1, 32'hB, 32'd5);
        tick();
        check("fl_skid_state", 32'(dbg_state), 32'(S_SKID));
        check("fl_skid_stall", 32'(stall_cnt), 32'd3);
        flush = 1'b1;
        drive(1'b1, 32'hD, 32'd6);
        tick();
        check("fl_valid", 32'(id_valid), 32'd0);
        check("fl_inst", id_inst, 32'h13);
        check("fl_ifrdy", 32'(if_ready), 32'd1);
        check("fl_pc_hold", id_pc, 32'd4);
        check("fl_stall", 32'(stall_cnt), 32'd3);
        flush = 1'b0;
        id_ready = 1'b1;
        drive(1'b1, 32'hE, 32'd9);
        tick();
        check("fl_e_inst", id_inst, 32'hE);
        check("fl_e_pc", id_pc, 32'd9);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("fl_end_valid", 32'(id_valid), 32'd0);

        // Drain to empty: single instruction 0x5 at pc 7
        drive(1'b1, 32'h5, 32'd7);
        tick();
        check("dr_inst", id_inst, 32'h5);
        check("dr_pc", id_pc, 32'd7);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("dr_valid", 32'(id_valid), 32'd0);
        check("dr_nop", id_inst, 32'h13);
        check("dr_pc_hold", id_pc, 32'd7);
        check("dr_pcp_hold", id_pc_plus, 32'd8);

        // Asynchronous reset mid-cycle while in SKID
        id_ready = 1'b0;
        drive(1'b1, 32'h21, 32'd20);
        tick();
        drive(1'b1, 32'h22, 32'd21);
        tick();
        check("rs_pre_state", 32'(dbg_state), 32'(S_SKID));
        check("rs_pre_stall", 32'(stall_cnt), 32'd4);
        #2 reset = 1'b0;
        #1;
        check("rs_valid", 32'(id_valid), 32'd0);
        check("rs_inst", id_inst, 32'h13);
        check("rs_pc", id_pc, 32'd0);
        check("rs_pcp", id_pc_plus, 32'd0);
        check("rs_ifrdy", 32'(if_ready), 32'd1);
        check("rs_stall", 32'(stall_cnt), 32'd0);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        #2 reset = 1'b1;

        // Saturation: hold a stalled valid instruction for 20 cycles
        drive(1'b1, 32'h33, 32'd30);
        tick();
        check("sat_start", 32'(stall_cnt), 32'd0);
        drive(1'b0, 32'h0, 32'h0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("sat_cnt", 32'(stall_cnt), (k < 15) ? 32'(k) : 32'd15);
        end
        check("sat_inst", id_inst, 32'h33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
